// File: rtl/mem_req_arbiter.sv
// Read-burst arbiter: grants one of NUM_CLIENTS miss handlers onto the SDRAM read port.
// Define MEMARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module mem_req_arbiter #(
    parameter  int NUM_CLIENTS = 4,
    parameter  int MAX_TRANS   = 16,
    localparam int TS_W        = $clog2(MAX_TRANS),
    localparam int GW          = $clog2(NUM_CLIENTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CLIENTS-1:0][24:0]     cl_addr,
    input  logic [NUM_CLIENTS-1:0][TS_W-1:0] cl_transSize,
    input  logic [NUM_CLIENTS-1:0]           cl_readReq,
    output logic [NUM_CLIENTS-1:0]           cl_readValid_out,
    output logic [31:0]                      cl_readData,
    output logic [NUM_CLIENTS-1:0]           cl_doneRead,
    output logic                             rd_req,
    output logic [24:0]                      rd_addr,
    output logic [TS_W-1:0]                  rd_len,
    input  logic                             rd_ack,
    input  logic                             rd_valid,
    input  logic [31:0]                      rd_data
);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] win;
    logic          any_req;
    logic [TS_W:0] cnt;
    logic [TS_W:0] cnt_inc;
    logic [TS_W:0] len_ext;
    logic          beat_ok;
    logic          beat;

`ifndef MEMARB_FIXED_PRIO_EN
    logic [GW-1:0] ptr;
    logic [GW-1:0] ptr_next;
`endif

    function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [GW-1:0] g);
        onehot    = '0;
        onehot[g] = 1'b1;
    endfunction

    // Winner search starts at the round-robin pointer (or index 0 in fixed priority).
    always_comb begin
        logic [GW-1:0] idx;
        win     = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
`ifdef MEMARB_FIXED_PRIO_EN
            idx = GW'(i);
`else
            idx = GW'((int'(ptr) + i) % NUM_CLIENTS);
`endif
            if (!any_req && cl_readReq[idx]) begin
                any_req = 1'b1;
                win     = idx;
            end
        end
    end

`ifndef MEMARB_FIXED_PRIO_EN
    assign ptr_next = (win == GW'(NUM_CLIENTS - 1)) ? '0 : win + GW'(1);
`endif

    // Counter is one bit wider than rd_len so a full-length burst never wraps.
    assign len_ext = {1'b0, rd_len};
    assign cnt_inc = cnt + {{TS_W{1'b0}}, rd_valid};

    // A beat together with the accept counts as beat 0; beats anywhere else are dropped.
    assign beat_ok          = (state == DATA) || ((state == REQ) && rd_ack);
    assign beat             = beat_ok && rd_valid;
    assign cl_readValid_out = beat ? onehot(grant) : '0;
    assign cl_readData      = beat ? rd_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            rd_len      <= '0;
            cnt         <= '0;
            cl_doneRead <= '0;
`ifndef MEMARB_FIXED_PRIO_EN
            ptr         <= '0;
`endif
        end else begin
            cl_doneRead <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        rd_addr <= cl_addr[win];
                        rd_len  <= cl_transSize[win];
                        grant   <= win;
                        cnt     <= '0;
`ifndef MEMARB_FIXED_PRIO_EN
                        ptr     <= ptr_next;
`endif
                        if (cl_transSize[win] == '0) begin
                            state       <= DONE;
                            cl_doneRead <= onehot(win);
                        end else begin
                            state  <= REQ;
                            rd_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (rd_ack) begin
                        rd_req <= 1'b0;
                        cnt    <= cnt_inc;
                        if (cnt_inc == len_ext) begin
                            state       <= DONE;
                            cl_doneRead <= onehot(grant);
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (rd_valid) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == len_ext) begin
                            state       <= DONE;
                            cl_doneRead <= onehot(grant);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Arbitrates read-burst requests from `NUM_CLIENTS` cache miss handlers onto the single SDRAM controller read port. It latches the winning client's start address and burst length and issues one burst request to the controller. Returned words are steered back to the granted client, and that client gets a one-cycle `doneRead` after the last word. The block sits directly downstream of the miss handlers and upstream of the SDRAM controller.

## Interface
- `NUM_CLIENTS`, 4: number of miss-handler clients, ≥2.
- `MAX_TRANS`, 16: maximum burst length in words; `TS_W = $clog2(MAX_TRANS)`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cl_addr` in [NUM_CLIENTS-1:0][24:0]: per-client word address, sampled only at grant.
- `cl_transSize` in [NUM_CLIENTS-1:0][TS_W-1:0]: per-client burst length, sampled at grant.
- `cl_readReq` in [NUM_CLIENTS-1:0]: request; held by the client until its `cl_doneRead`.
- `cl_readValid_out` out [NUM_CLIENTS-1:0]: one-hot data strobe to the granted client.
- `cl_readData` out 32: returned word, broadcast to all clients.
- `cl_doneRead` out [NUM_CLIENTS-1:0]: one-hot, one-cycle burst-complete pulse.
- `rd_req` out 1: burst request to the controller.
- `rd_addr` out 25: registered start address.
- `rd_len` out TS_W: registered burst length.
- `rd_ack` in 1: controller accepted `rd_req`.
- `rd_valid` in 1: controller data beat.
- `rd_data` in 32: controller data word.

## Operation
- FSM states: IDLE, REQ, DATA, DONE.
- **IDLE:**
  - If any `cl_readReq` bit is set, select winner `g`.
  - Load `rd_addr`←`cl_addr[g]`, `rd_len`←`cl_transSize[g]`, `grant`←`g`; clear the beat counter.
  - Go to REQ. If `cl_transSize[g]==0`, go directly to DONE instead.
  - Otherwise stay in IDLE.
- **REQ:** `rd_req=1`. On `rd_ack`, go to DATA. `rd_valid` arriving in the same cycle as `rd_ack` counts as beat 0.
- **DATA:**
  - Each `rd_valid`: counter += 1; `cl_readValid_out[grant]=rd_valid` and `cl_readData=rd_data`, both combinational.
  - When the counter reaches `rd_len` (after the last beat's edge), go to DONE.
- **DONE:** `cl_doneRead[grant]=1` for exactly one cycle, then IDLE.
- **Round-robin:**
  - Pointer `p` (`$clog2(NUM_CLIENTS)` bits, reset 0).
  - Winner is the first requesting index searching `p, p+1, …` modulo `NUM_CLIENTS`.
  - On grant, `p`←`g+1` (wraps).
- `cl_addr` changes after grant (the client increments it per beat) and are ignored; only the latched `rd_addr` matters.
- Client drops `cl_readReq` mid-burst: the burst still completes, and `cl_doneRead` still pulses to that client.
- `rd_valid` outside REQ/DATA is dropped, with no strobe to any client. The bench flags it as a protocol error.
- Counter width is TS_W+1 bits, so `rd_len = MAX_TRANS-1` cannot wrap.

## Timing
- Reset values: state IDLE, `p`=0, `grant`=0, `rd_req`=0, `rd_addr`=0, `rd_len`=0, counter 0, all `cl_readValid_out`=0, all `cl_doneRead`=0, `cl_readData`=0.
- Request at cycle t (IDLE) → `rd_req` high at t+1.
- `rd_ack` at cycle a → last beat at cycle b → `cl_doneRead` at b+1 → IDLE at b+2.
- `cl_doneRead` never coincides with the last `cl_readValid_out`; the client's data register is already updated when it sees done.
- A new grant is earliest at b+2, by which time the finished client's `cl_readReq` is already low.
- Minimum occupancy per burst: `rd_len`+3 cycles (IDLE, REQ, beats, DONE), given `rd_ack` and beats back-to-back.
- `rst` mid-burst: immediate return to reset state. Outstanding controller beats after reset are dropped.

## Configuration
- `MEMARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins; pointer `p` removed.
  - Undefined (default): round-robin as above.

## Test plan
- Single client 0, addr 0x0000100, len 8, `rd_ack` immediately, 8 back-to-back beats D0..D7:
  - `rd_req` at t+1, `rd_addr`=0x100, `rd_len`=8.
  - 8 `cl_readValid_out[0]` strobes with matching data.
  - `cl_doneRead[0]` one cycle after D7.
- Clients 0..3 request simultaneously, len 8 each → grants in order 0,1,2,3. With `MEMARB_FIXED_PRIO_EN` and client 0 re-requesting after done → 0 wins again.
- Client 2 len 12 with 3-cycle bubbles between beats and `rd_ack` delayed 5 cycles → `rd_req` held 5 cycles, exactly 12 strobes, done after the 12th.
- Client 1 increments `cl_addr` every beat → `rd_addr` stays at the grant value throughout.
- `cl_transSize`=0 → no `rd_req`; `cl_doneRead` pulses 1 cycle after grant.
- `rst` asserted after beat 3 of an 8-beat burst → all outputs at reset values in the same cycle; the next request restarts from `p`=0.
